rr_arbiter8: RTL

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a release handshake
// and an optional maximum grant length that produces a timeout pulse.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic       timeout
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
    localparam logic HOLD_EN = (HOLD_MAX != 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_n;
    logic [N-1:0]       gnt_n;
    logic               gnt_valid_n;
    logic [IDX_W-1:0]   gnt_idx_n;
    logic               timeout_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   cand;
    logic               forced;
    logic               holder_req;

    // First requester searching upward from ptr+1, wrapping; ptr itself is tried last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int i = 1; i <= N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign holder_req = req[gnt_idx];
    assign forced     = HOLD_EN && (hold_cnt == HOLD_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        gnt_valid_n = gnt_valid;
        gnt_idx_n   = gnt_idx;
        timeout_n   = 1'b0;
        ptr_n       = ptr;
        hold_cnt_n  = hold_cnt;

        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n     = GRANT;
                    gnt_n       = N'(1) << sel_idx;
                    gnt_valid_n = 1'b1;
                    gnt_idx_n   = sel_idx;
                    ptr_n       = sel_idx;
                    hold_cnt_n  = '0;
                end
            end
            GRANT: begin
                if (done || !holder_req || forced) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    gnt_valid_n = 1'b0;
                    gnt_idx_n   = '0;
                    // A concurrent voluntary release masks the timeout.
                    timeout_n   = forced && !done && holder_req;
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_n       = '0;
                gnt_valid_n = 1'b0;
                gnt_idx_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
            ptr       <= IDX_W'(N - 1);
            hold_cnt  <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
            gnt_idx   <= gnt_idx_n;
            timeout   <= timeout_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_cnt_n;
        end
    end

endmodule
